// File: rtl/rob_multiport.sv
// Reorder buffer: allocates in program order, takes out-of-order completions on
// NUM_CPL ports, retires in order up to RET_W per cycle, supports flush and preg lookup.
module rob_multiport #(
  parameter int DEPTH   = 16,
  parameter int PC_W    = 32,
  parameter int PREG_W  = 6,
  parameter int NUM_CPL = 4,
  parameter int RET_W   = 2,
  parameter int IW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
  input  logic                      disp_valid,
  input  logic [PC_W-1:0]           disp_pc,
  input  logic [4:0]                disp_arch_dr,
  input  logic [PREG_W-1:0]         disp_dr_p,
  input  logic [PREG_W-1:0]         disp_old_dr_p,
  input  logic                      disp_reg_write,
  input  logic                      disp_is_store,
  output logic                      disp_ready,
  output logic [IW-1:0]             disp_rob_idx,
  input  logic [NUM_CPL-1:0]        cpl_valid,
  input  logic [NUM_CPL*IW-1:0]     cpl_rob_idx,
  input  logic [NUM_CPL*PC_W-1:0]   cpl_data,
  input  logic [PREG_W-1:0]         src1_p,
  input  logic [PREG_W-1:0]         src2_p,
  output logic                      src1_hit,
  output logic                      src2_hit,
  output logic                      src1_ready,
  output logic                      src2_ready,
  output logic [PC_W-1:0]           src1_value,
  output logic [PC_W-1:0]           src2_value,
  output logic [RET_W-1:0]          ret_valid,
  output logic [RET_W*PC_W-1:0]     ret_pc,
  output logic [RET_W*PC_W-1:0]     ret_data,
  output logic [RET_W*5-1:0]        ret_arch_dr,
  output logic [RET_W*PREG_W-1:0]   ret_dr_p,
  output logic [RET_W*PREG_W-1:0]   ret_old_dr_p,
  output logic [RET_W-1:0]          ret_reg_write,
  output logic [RET_W-1:0]          ret_is_store,
  output logic [IW:0]               count
);

  // Dispatch handshake: an entry is allocated on a rising edge where
  // disp_valid & disp_ready & ~flush; disp_ready depends only on registered count.

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  done_q;
  logic [DEPTH-1:0]  rw_q;
  logic [DEPTH-1:0]  st_q;
  logic [PC_W-1:0]   pc_q     [DEPTH];
  logic [PC_W-1:0]   data_q   [DEPTH];
  logic [4:0]        arch_q   [DEPTH];
  logic [PREG_W-1:0] drp_q    [DEPTH];
  logic [PREG_W-1:0] old_q    [DEPTH];
  logic [IW-1:0]     head_q;
  logic [IW-1:0]     tail_q;
  logic [IW:0]       count_q;

  logic              disp_fire;
  logic [DEPTH-1:0]  cpl_set;
  logic [PC_W-1:0]   cpl_word [DEPTH];
  logic [DEPTH-1:0]  ret_clr;
  logic [1:0]        ret_cnt;
  logic              ret_chain;
  logic [IW-1:0]     ret_idx;
  logic [PREG_W-1:0] src_key  [2];
  logic [1:0]        lk_hit;
  logic [1:0]        lk_done;
  logic [PC_W-1:0]   lk_data  [2];
  logic [IW-1:0]     lk_idx;

  assign disp_ready   = (count_q != (IW+1)'(DEPTH));
  assign disp_rob_idx = tail_q;
  assign count        = count_q;
  assign disp_fire    = disp_valid & disp_ready & ~flush;

  // Lowest-numbered port wins on duplicate indices: scan from the top down.
  always_comb begin
    cpl_set = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cpl_word[i] = '0;
      for (int k = NUM_CPL - 1; k >= 0; k--) begin
        if (cpl_valid[k] && (cpl_rob_idx[k*IW +: IW] == IW'(i))) begin
          cpl_set[i]  = 1'b1;
          cpl_word[i] = cpl_data[k*PC_W +: PC_W];
        end
      end
      if (!valid_q[i] || (disp_fire && (tail_q == IW'(i))))
        cpl_set[i] = 1'b0;
    end
  end

  always_comb begin
    ret_valid     = '0;
    ret_cnt       = '0;
    ret_clr       = '0;
    ret_chain     = 1'b1;
    ret_idx       = head_q;
    ret_pc        = '0;
    ret_data      = '0;
    ret_arch_dr   = '0;
    ret_dr_p      = '0;
    ret_old_dr_p  = '0;
    ret_reg_write = '0;
    ret_is_store  = '0;
    for (int k = 0; k < RET_W; k++) begin
      ret_idx      = head_q + IW'(k);
      ret_chain    = ret_chain & valid_q[ret_idx] & done_q[ret_idx];
      ret_valid[k] = ret_chain;
      if (ret_chain) begin
        ret_cnt          = ret_cnt + 2'd1;
        ret_clr[ret_idx] = 1'b1;
      end
      ret_pc[k*PC_W +: PC_W]         = pc_q[ret_idx];
      ret_data[k*PC_W +: PC_W]       = data_q[ret_idx];
      ret_arch_dr[k*5 +: 5]          = arch_q[ret_idx];
      ret_dr_p[k*PREG_W +: PREG_W]   = drp_q[ret_idx];
      ret_old_dr_p[k*PREG_W +: PREG_W] = old_q[ret_idx];
      ret_reg_write[k]               = rw_q[ret_idx];
      ret_is_store[k]                = st_q[ret_idx];
    end
  end

  assign src_key[0] = src1_p;
  assign src_key[1] = src2_p;

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    lk_hit  = '0;
    lk_done = '0;
    lk_idx  = head_q;
    for (int s = 0; s < 2; s++) begin
      lk_data[s] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        lk_idx = head_q + IW'(j);
        if ((src_key[s] != '0) && valid_q[lk_idx] && rw_q[lk_idx] &&
            (drp_q[lk_idx] == src_key[s])) begin
          lk_hit[s]  = 1'b1;
          lk_done[s] = done_q[lk_idx];
          lk_data[s] = data_q[lk_idx];
        end
      end
    end
  end

  assign src1_hit   = lk_hit[0];
  assign src2_hit   = lk_hit[1];
  assign src1_ready = ~lk_hit[0] | lk_done[0];
  assign src2_ready = ~lk_hit[1] | lk_done[1];
  assign src1_value = (lk_hit[0] && lk_done[0]) ? lk_data[0] : '0;
  assign src2_value = (lk_hit[1] && lk_done[1]) ? lk_data[1] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (disp_fire)
        tail_q <= tail_q + IW'(1);
      head_q  <= head_q + IW'(ret_cnt);
      count_q <= count_q + (IW+1)'(disp_fire) - (IW+1)'(ret_cnt);
      for (int i = 0; i < DEPTH; i++) begin
        if (disp_fire && (tail_q == IW'(i))) begin
          valid_q[i] <= 1'b1;
          done_q[i]  <= 1'b0;
        end else begin
          if (cpl_set[i])
            done_q[i] <= 1'b1;
          if (ret_clr[i])
            valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Payload carries no reset: it is only observed through valid/done.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (disp_fire && (tail_q == IW'(i))) begin
        pc_q[i]   <= disp_pc;
        arch_q[i] <= disp_arch_dr;
        drp_q[i]  <= disp_dr_p;
        old_q[i]  <= disp_old_dr_p;
        rw_q[i]   <= disp_reg_write;
        st_q[i]   <= disp_is_store;
      end
      if (cpl_set[i])
        data_q[i] <= cpl_word[i];
    end
  end

endmodule

// File: doc/rob_multiport.md
# rob_multiport

Parametrised reorder buffer for the out-of-order core: a circular buffer of `DEPTH` entries allocated in program order at dispatch (after rename), marked complete by up to `NUM_CPL` functional-unit completion ports, and retired in order up to `RET_W` per cycle toward the ARF and the rename free list. It generalises the single-dispatch ROB with configurable depth, completion-port count and retire width, and adds flush, occupancy reporting and per-physical-register ready/value lookup for the issue queue.

## Interface
- `DEPTH`, 16: entry count; power of two, ≥4.
- `PC_W`, 32: PC / data width.
- `PREG_W`, 6: physical register index width.
- `NUM_CPL`, 4: completion ports.
- `RET_W`, 2: max retirements per cycle; 1 or 2.
- `IW` = $clog2(DEPTH), derived.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous squash of all entries.
- `disp_valid` in 1: dispatch request.
- `disp_pc` in PC_W: instruction PC.
- `disp_arch_dr` in 5: architectural destination.
- `disp_dr_p` in PREG_W: new physical destination.
- `disp_old_dr_p` in PREG_W: previous mapping, freed at retire.
- `disp_reg_write` in 1: instruction writes a register.
- `disp_is_store` in 1: store instruction.
- `disp_ready` out 1: entry available.
- `disp_rob_idx` out IW: index the dispatching instruction receives (= tail).
- `cpl_valid` in NUM_CPL: per-port completion strobe.
- `cpl_rob_idx` in NUM_CPL*IW: packed entry indices.
- `cpl_data` in NUM_CPL*PC_W: packed result values.
- `src1_p`, `src2_p` in PREG_W: lookup keys.
- `src1_hit`, `src2_hit` out 1: an in-flight entry owns this preg.
- `src1_ready`, `src2_ready` out 1: value available (hit & done, or no hit).
- `src1_value`, `src2_value` out PC_W: entry result when hit & done, else 0.
- `ret_valid` out RET_W: retire slot k valid this cycle.
- `ret_pc`, `ret_data` out RET_W*PC_W; `ret_arch_dr` out RET_W*5; `ret_dr_p`, `ret_old_dr_p` out RET_W*PREG_W; `ret_reg_write`, `ret_is_store` out RET_W.
- `count` out IW+1: occupied entries.

## Operation
- Per-entry state: valid, done, pc, arch_dr, dr_p, old_dr_p, reg_write, is_store, data. Pointers `head`, `tail` (IW bits, wrap modulo DEPTH) and `count`.
- Dispatch: on edge with `disp_valid & disp_ready & ~flush`, write entry[tail], valid=1, done=0; tail+1.
- `disp_ready = (count != DEPTH)`, from registered count only; same-cycle retirement does not free a slot for that cycle's dispatch.
- Completion: each port with `cpl_valid[k]` and entry[idx].valid sets done=1, data=cpl_data[k]. Completion to an invalid entry is ignored. Duplicate indices in one cycle: lowest port wins. Completion to an entry being allocated the same cycle is ignored.
- Retire (combinational from registered state): slot0 valid = entry[head].valid & done; slot1 (RET_W=2) valid = slot0 & entry[head+1].valid & done. Retiring entries clear valid on the edge; head += number retired. No backpressure.
- `count_next = count + dispatched − retired`.
- Lookup: search valid entries for dr_p == src_p with reg_write=1; youngest match (closest to tail) wins. Reads registered state only; no same-cycle completion bypass. `src_p == 0` always returns hit=0, ready=1.
- Flush: priority over dispatch, completion and retire; next state head=tail=count=0, all valid cleared; `ret_valid` still reflects the pre-flush cycle combinationally but the bench must not treat it as committed (flush suppresses pointer update).

## Timing
- Reset (async): head=tail=count=0, all valid/done=0; outputs `disp_ready`=1, `disp_rob_idx`=0, `ret_valid`=0, `src*_hit`=0, `src*_ready`=1, values 0.
- Dispatch→complete: earliest completion 1 cycle after dispatch edge.
- Complete→retire: `ret_valid` high the cycle after completion edge if entry is at head.
- Dispatch→retire minimum: 2 cycles.
- Full: count==DEPTH → disp_ready=0; reasserts the cycle after any retirement.
- Wrap: tail/head wrap from DEPTH−1 to 0 without bubble.
- Reset mid-operation discards all entries immediately.

## Test plan
- Reset, dispatch 3 instrs (PC 0,4,8) → rob_idx 0,1,2, count=3, ret_valid=0.
- Complete idx 2 then idx 0 (data 0x11) → cycle after idx0 completion ret_valid=01, ret_pc=0, ret_data=0x11; idx1 blocks idx2 until completed, then both retire same cycle (ret_valid=11).
- Fill 16 entries → disp_ready=0 with disp_valid held; retire one → disp_ready=1 next cycle, new entry gets idx 0 (wrap).
- Two entries dest p7, older done (0x5), younger pending → src1_p=7 gives hit=1, ready=0; complete younger with 0x9 → next cycle ready=1, value=0x9.
- Ports 0 and 3 complete same idx with 0xA/0xB → data 0xA retired.
- Flush with 5 in flight plus simultaneous dispatch → next cycle count=0, disp_rob_idx=0, no entry retires afterward.
